// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock, carry rippled through a register.
// Optional signed-overflow output enabled by defining SEQ_CHUNK_ADDER_OVF_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;

    logic [CHUNK:0]   add_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic             chunk_cout_s;
    logic [WIDTH-1:0] sum_ext_s;
    logic [WIDTH-1:0] res_next_s;

    // Ripple one chunk using the p/g full-adder cell; returns {carry_out, sum}.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c_in);
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] sum;
        logic             c;
        c = c_in;
        for (int i = 0; i < CHUNK; i++) begin
            p[i]   = x[i] ^ y[i];
            g[i]   = x[i] & y[i];
            sum[i] = p[i] ^ c;
            c      = g[i] | (p[i] & c);
        end
        return {c, sum};
    endfunction

    // Chunk datapath: add the low chunk and insert its sum at the MSB end of the result.
    always_comb begin
        add_s        = chunk_add(op_a_r[CHUNK-1:0], op_b_r[CHUNK-1:0], carry_r);
        chunk_sum_s  = add_s[CHUNK-1:0];
        chunk_cout_s = add_s[CHUNK];
        sum_ext_s    = '0;
        sum_ext_s[WIDTH-1 -: CHUNK] = chunk_sum_s;
        res_next_s   = (res_r >> CHUNK) | sum_ext_s;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            op_a_r  <= '0;
            op_b_r  <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a_r  <= a;
                        op_b_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    op_a_r  <= op_a_r >> CHUNK;
                    op_b_r  <= op_b_r >> CHUNK;
                    carry_r <= chunk_cout_s;
                    res_r   <= res_next_s;
                    if (cnt_r == LAST_CNT) begin
                        s       <= res_next_s;
                        cout    <= chunk_cout_s;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                        // Carry into the MSB is recovered from sum ^ a ^ b at that bit.
                        ovf     <= chunk_sum_s[CHUNK-1] ^ op_a_r[CHUNK-1] ^ op_b_r[CHUNK-1]
                                   ^ chunk_cout_s;
`endif
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    // The DONE exit edge doubles as an accept slot so a held start sustains one op per NCHUNK+1 cycles.
                    if (start) begin
                        op_a_r  <= a;
                        op_b_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (32/8 instance plus an 8/8 instance).
// Ovf checks compile in when SEQ_CHUNK_ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, cin, busy, done, cout;
    logic [31:0] a, b, s;
    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, s8;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic        ovf, ovf8;
    logic        last_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .s(s), .cout(cout)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // Launch one op on the 32-bit DUT and wait (bounded) for its done pulse.
    task automatic run_op32(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                            output logic [31:0] os, output logic oc, output int lat);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; os = '0; oc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k; os = s; oc = cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                last_ovf = ovf;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, s, cout} !== 35'd0) begin
            n_fail++; $display("FAIL reset32: got busy=%b done=%b s=%h cout=%b, want all 0", busy, done, s, cout);
        end
        n_checks++;
        if ({busy8, done8, s8, cout8} !== 11'd0) begin
            n_fail++; $display("FAIL reset8: got busy=%b done=%b s=%h cout=%b, want all 0", busy8, done8, s8, cout8);
        end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    endtask

    task automatic test_basic();
        int busy_cnt, done_at, done_cnt;
        logic [31:0] rs;
        logic        rc;
        a = 32'h0000_0001; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        done_at = -1; done_cnt = 0; rs = '0; rc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) busy_cnt++;
            if (k == 1) begin
                n_checks++;
                if (s !== 32'd0) begin n_fail++; $display("FAIL hold_during_run: got s=%h want 00000000", s); end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; rs = s; rc = cout; end
            end
        end
        n_checks++;
        if (done_at != 4) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 4", done_at); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_checks++;
        if (busy_cnt != 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 5", busy_cnt); end
        n_checks++;
        if ({rc, rs} !== 33'h0_0000_0002) begin
            n_fail++; $display("FAIL basic_sum: got cout=%b s=%h want cout=0 s=00000002", rc, rs);
        end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] rs; logic rc; int lat;
        run_op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, rs, rc, lat);
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL ripple_latency: got %0d want 4", lat); end
        n_checks++;
        if ({rc, rs} !== 33'h1_0000_0000) begin
            n_fail++; $display("FAIL ripple_sum: got cout=%b s=%h want cout=1 s=00000000", rc, rs);
        end
        run_op32(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, rs, rc, lat);
        n_checks++;
        if ({rc, rs} !== 33'h0_F0E2_1568 || lat != 4) begin
            n_fail++; $display("FAIL mixed_sum: got cout=%b s=%h lat=%0d want cout=0 s=f0e21568 lat=4", rc, rs, lat);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rs; logic rc; int lat;
        run_op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, rs, rc, lat);
        n_checks++;
        if ({rc, rs} !== 33'h0_8000_0000 || lat != 4) begin
            n_fail++; $display("FAIL ovf_pos_sum: got cout=%b s=%h lat=%0d want cout=0 s=80000000", rc, rs, lat);
        end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        n_checks++;
        if (last_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag: got %b want 1", last_ovf); end
`endif
        run_op32(32'h8000_0000, 32'h8000_0000, 1'b0, rs, rc, lat);
        n_checks++;
        if ({rc, rs} !== 33'h1_0000_0000) begin
            n_fail++; $display("FAIL ovf_neg_sum: got cout=%b s=%h want cout=1 s=00000000", rc, rs);
        end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        n_checks++;
        if (last_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_flag: got %b want 1", last_ovf); end
        run_op32(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, rs, rc, lat);
        n_checks++;
        if (last_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none_flag: got %b want 0", last_ovf); end
`endif
    endtask

    task automatic test_start_while_busy();
        int done_cnt;
        logic [31:0] rs; logic rc;
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0; rs = '0; rc = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin done_cnt++; rs = s; rc = cout; end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL busy_ignore_count: got %0d dones want 1", done_cnt); end
        n_checks++;
        if ({rc, rs} !== 33'h0_2345_6789) begin
            n_fail++; $display("FAIL busy_ignore_sum: got cout=%b s=%h want cout=0 s=23456789", rc, rs);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_cnt, lat;
        logic [31:0] rs; logic rc;
        a = 32'h0000_0005; b = 32'h0000_0006; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, s, cout} !== 35'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got busy=%b done=%b s=%h cout=%b want all 0", busy, done, s, cout);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles want 0", done_cnt); end
        run_op32(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, rs, rc, lat);
        n_checks++;
        if ({rc, rs} !== 33'h0_FFFF_FFFF || lat != 4) begin
            n_fail++; $display("FAIL midreset_recover: got cout=%b s=%h lat=%0d want cout=0 s=ffffffff lat=4", rc, rs, lat);
        end
    endtask

    // Single-chunk instance with start held high: one result every second cycle.
    task automatic test_back_to_back();
        logic [8:0] exp;
        int bad_ctl, bad_sum;
        bad_ctl = 0; bad_sum = 0;
        start8 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            exp = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
            @(posedge clk); #1;
            n_checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b1) begin
                n_fail++; bad_ctl++;
                if (bad_ctl < 5) $display("FAIL b2b_accept op %0d: got done=%b busy=%b want done=0 busy=1", i, done8, busy8);
            end
            a8 = ~a8; b8 = 8'($urandom); cin8 = ~cin8;
            @(posedge clk); #1;
            n_checks++;
            if (done8 !== 1'b1 || {cout8, s8} !== exp) begin
                n_fail++; bad_sum++;
                if (bad_sum < 5) $display("FAIL b2b_result op %0d: got done=%b {cout,s}=%h want done=1 %h", i, done8, {cout8, s8}, exp);
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_carry_ripple();
        test_overflow();
        repeat (2) @(posedge clk);
        #1;
        test_start_while_busy();
        test_reset_mid_op();
        repeat (2) @(posedge clk);
        #1;
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
